sram_banked_2p_wrap: RTL and testbench



---
 rtl/sram_banked_2p_wrap_pkg.sv | 18 +
 rtl/SRAM1D_WRAP.sv | 29 ++
 rtl/sram_wbuf.sv | 77 +++++++
 rtl/sram_banked_2p_wrap.sv | 189 ++++++++++++++++++
 tb/tb_sram_banked_2p_wrap.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_banked_2p_wrap_pkg.sv
// Shared definitions for the banked pseudo-two-port SRAM wrapper.
//   state_t : controller states (zero-fill init, then normal operation)
//   log2    : ceiling log2, used to size bank-index and counter fields
package sram_banked_2p_wrap_pkg;

  typedef enum logic {
    ST_Init  = 1'b0,
    ST_Ready = 1'b1
  } state_t;

  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/SRAM1D_WRAP.sv
// Single-port synchronous SRAM wrapper (behavioural model of the macro).
//   Clock   : clock
//   Enable  : chip enable; no access when 0
//   Write   : 1 = write DIn to Address, 0 = read Address
//   Address : word address
//   DIn     : write data
//   DOut    : read data, registered, valid the cycle after a read
module SRAM1D_WRAP #(
  parameter int unsigned DWidth = 64,
  parameter int unsigned AWidth = 9
) (
  input  logic              Clock,
  input  logic              Enable,
  input  logic              Write,
  input  logic [AWidth-1:0] Address,
  input  logic [DWidth-1:0] DIn,
  output logic [DWidth-1:0] DOut
);

  logic [DWidth-1:0] mem [2**AWidth];

  always_ff @(posedge Clock) begin
    if (Enable) begin
      if (Write) mem[Address] <= DIn;
      else       DOut         <= mem[Address];
    end
  end

endmodule

// File: rtl/sram_wbuf.sv
// In-order write buffer of {addr, data} entries.
//   Clock, Reset_N        : clock, synchronous active-low reset (empties buffer)
//   push, push_addr/data  : enqueue at tail (caller guarantees not full)
//   pop                   : dequeue head (caller guarantees not empty)
//   full, empty           : occupancy flags
//   head_addr, head_data  : oldest entry
//   probe_addr            : lookup address
//   probe_hit, probe_data : youngest entry matching probe_addr (combinational)
module sram_wbuf #(
  parameter int unsigned AWidth = 10,
  parameter int unsigned DWidth = 64,
  parameter int unsigned Depth  = 2
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic              push,
  input  logic [AWidth-1:0] push_addr,
  input  logic [DWidth-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AWidth-1:0] head_addr,
  output logic [DWidth-1:0] head_data,
  input  logic [AWidth-1:0] probe_addr,
  output logic              probe_hit,
  output logic [DWidth-1:0] probe_data
);

  localparam int unsigned CW = $clog2(Depth + 1);

  logic [CW-1:0]     count;
  logic [AWidth-1:0] addr_q [Depth];
  logic [DWidth-1:0] data_q [Depth];
  int unsigned       wr_idx;

  assign full      = (count == CW'(Depth));
  assign empty     = (count == '0);
  assign head_addr = addr_q[0];
  assign head_data = data_q[0];

  // Slot 0 is always the head; a simultaneous pop shifts the tail down by one.
  always_comb begin
    wr_idx = 32'(count);
    if (pop) wr_idx = 32'(count) - 32'd1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) count <= '0;
    else          count <= count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clock) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (pop && (i + 1 < Depth)) begin
        addr_q[i] <= addr_q[i+1];
        data_q[i] <= data_q[i+1];
      end
      if (push && (i == wr_idx)) begin
        addr_q[i] <= push_addr;
        data_q[i] <= push_data;
      end
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    probe_hit  = 1'b0;
    probe_data = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if ((i < 32'(count)) && (addr_q[i] == probe_addr)) begin
        probe_hit  = 1'b1;
        probe_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/sram_banked_2p_wrap.sv
// Pseudo-two-port memory (1 read + 1 write per cycle) built from NBanks
// low-order interleaved single-port banks. Same-bank read/write conflicts are
// absorbed by an in-order write buffer with read forwarding. With InitZero=1
// the whole array is zero-filled after reset before Ready rises.
//   Clock, Reset_N            : clock, synchronous active-low reset
//   Ready                     : init complete; requests accepted only when 1
//   Read, ReadAddress         : read request (always accepted when Ready)
//   ReadValid, DOut           : read response one cycle later; DOut=0 otherwise
//   Write, WriteAddress, DIn  : write request, accepted iff Write && WriteReady
//   WriteReady                : Ready && write buffer not full
module sram_banked_2p_wrap
  import sram_banked_2p_wrap_pkg::*;
#(
  parameter int unsigned DWidth   = 64,
  parameter int unsigned AWidth   = 10,
  parameter int unsigned NBanks   = 2,
  parameter int unsigned WBDepth  = 2,
  parameter bit          InitZero = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset_N,
  output logic              Ready,
  input  logic              Read,
  input  logic [AWidth-1:0] ReadAddress,
  output logic              ReadValid,
  output logic [DWidth-1:0] DOut,
  input  logic              Write,
  input  logic [AWidth-1:0] WriteAddress,
  input  logic [DWidth-1:0] DIn,
  output logic              WriteReady
);

  localparam int unsigned BW  = log2(NBanks);
  localparam int unsigned BAW = AWidth - BW;

  state_t            state;
  logic              ready_q;
  logic [BAW-1:0]    init_cnt;

  logic              rv_q;
  logic              fwd_hit_q;
  logic [DWidth-1:0] fwd_data_q;
  logic [BW-1:0]     bank_sel_q;

  logic              rd_acc, wr_acc, drain, direct, enq;
  logic [BW-1:0]     rd_bank, wr_bank, head_bank;
  logic [BAW-1:0]    rd_baddr, wr_baddr, head_baddr;

  logic              wb_full, wb_empty;
  logic [AWidth-1:0] wb_head_addr;
  logic [DWidth-1:0] wb_head_data;
  logic              wb_hit;
  logic [DWidth-1:0] wb_hit_data;

  logic              bank_ce   [NBanks];
  logic              bank_we   [NBanks];
  logic [BAW-1:0]    bank_addr [NBanks];
  logic [DWidth-1:0] bank_din  [NBanks];
  logic [DWidth-1:0] bank_dout [NBanks];

  assign Ready      = ready_q;
  assign WriteReady = ready_q && !wb_full;

  assign rd_bank    = ReadAddress[BW-1:0];
  assign rd_baddr   = ReadAddress[AWidth-1:BW];
  assign wr_bank    = WriteAddress[BW-1:0];
  assign wr_baddr   = WriteAddress[AWidth-1:BW];
  assign head_bank  = wb_head_addr[BW-1:0];
  assign head_baddr = wb_head_addr[AWidth-1:BW];

  // Priority: read owns its bank, then buffer head drains, then an incoming
  // write may bypass the buffer only when the buffer is empty (keeps order).
  assign rd_acc = Read && ready_q;
  assign wr_acc = Write && WriteReady;
  assign drain  = ready_q && !wb_empty && !(rd_acc && (head_bank == rd_bank));
  assign direct = wr_acc && wb_empty && !(rd_acc && (wr_bank == rd_bank));
  assign enq    = wr_acc && !direct;

  sram_wbuf #(
    .AWidth (AWidth),
    .DWidth (DWidth),
    .Depth  (WBDepth)
  ) u_wbuf (
    .Clock      (Clock),
    .Reset_N    (Reset_N),
    .push       (enq),
    .push_addr  (WriteAddress),
    .push_data  (DIn),
    .pop        (drain),
    .full       (wb_full),
    .empty      (wb_empty),
    .head_addr  (wb_head_addr),
    .head_data  (wb_head_data),
    .probe_addr (ReadAddress),
    .probe_hit  (wb_hit),
    .probe_data (wb_hit_data)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state      <= ST_Init;
      ready_q    <= 1'b0;
      init_cnt   <= '0;
      rv_q       <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      bank_sel_q <= '0;
    end else begin
      case (state)
        ST_Init: begin
          if (!InitZero) begin
            state   <= ST_Ready;
            ready_q <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == '1) begin
              state   <= ST_Ready;
              ready_q <= 1'b1;
            end
          end
        end
        ST_Ready: ;
        default: begin
          state   <= ST_Init;
          ready_q <= 1'b0;
        end
      endcase

      rv_q <= rd_acc;
      if (rd_acc) begin
        // Forwarded data is captured from the buffer state at request time.
        bank_sel_q <= rd_bank;
        fwd_hit_q  <= wb_hit;
        fwd_data_q <= wb_hit_data;
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NBanks; b++) begin
      bank_ce[b]   = 1'b0;
      bank_we[b]   = 1'b0;
      bank_addr[b] = '0;
      bank_din[b]  = '0;
      if (state == ST_Init) begin
        if (InitZero) begin
          bank_ce[b]   = 1'b1;
          bank_we[b]   = 1'b1;
          bank_addr[b] = init_cnt;
        end
      end else if (rd_acc && (rd_bank == BW'(b))) begin
        bank_ce[b]   = 1'b1;
        bank_addr[b] = rd_baddr;
      end else if (drain && (head_bank == BW'(b))) begin
        bank_ce[b]   = 1'b1;
        bank_we[b]   = 1'b1;
        bank_addr[b] = head_baddr;
        bank_din[b]  = wb_head_data;
      end else if (direct && (wr_bank == BW'(b))) begin
        bank_ce[b]   = 1'b1;
        bank_we[b]   = 1'b1;
        bank_addr[b] = wr_baddr;
        bank_din[b]  = DIn;
      end
    end
  end

  for (genvar g = 0; g < NBanks; g++) begin : g_bank
    SRAM1D_WRAP #(
      .DWidth (DWidth),
      .AWidth (BAW)
    ) u_bank (
      .Clock   (Clock),
      .Enable  (bank_ce[g]),
      .Write   (bank_we[g]),
      .Address (bank_addr[g]),
      .DIn     (bank_din[g]),
      .DOut    (bank_dout[g])
    );
  end

  always_comb begin
    DOut = '0;
    if (rv_q) DOut = fwd_hit_q ? fwd_data_q : bank_dout[bank_sel_q];
  end

  assign ReadValid = rv_q;

endmodule

// File: tb/tb_sram_banked_2p_wrap.sv
// Self-checking bench for sram_banked_2p_wrap (AWidth=4, NBanks=2, WBDepth=2,
// InitZero=1). A reference array models read-first memory semantics; read
// expectations are queued when a read is driven and popped on ReadValid.
module tb_sram_banked_2p_wrap;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned NB  = 2;
  localparam int unsigned WBD = 2;

  logic          Clock = 1'b0;
  logic          Reset_N;
  logic          Ready;
  logic          Read;
  logic [AW-1:0] ReadAddress;
  logic          ReadValid;
  logic [DW-1:0] DOut;
  logic          Write;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] DIn;
  logic          WriteReady;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q [$];

  always #5 Clock = ~Clock;

  sram_banked_2p_wrap #(
    .DWidth   (DW),
    .AWidth   (AW),
    .NBanks   (NB),
    .WBDepth  (WBD),
    .InitZero (1'b1)
  ) dut (
    .Clock        (Clock),
    .Reset_N      (Reset_N),
    .Ready        (Ready),
    .Read         (Read),
    .ReadAddress  (ReadAddress),
    .ReadValid    (ReadValid),
    .DOut         (DOut),
    .Write        (Write),
    .WriteAddress (WriteAddress),
    .DIn          (DIn),
    .WriteReady   (WriteReady)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_output(input bit exp_rv);
    logic [DW-1:0] e;
    check_val("read_valid", ReadValid, exp_rv);
    if (exp_rv) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: got response expected none queued");
      end else begin
        e = exp_q.pop_front();
        check_val("dout", DOut, e);
      end
    end else begin
      check_val("dout_idle", DOut, '0);
    end
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit rd, input int raddr, input bit wr, input int waddr,
                       input logic [DW-1:0] wdata, input bit exp_wrdy);
    Read         = rd;
    ReadAddress  = AW'(raddr);
    Write        = wr;
    WriteAddress = AW'(waddr);
    DIn          = wdata;
    #1;
    check_val("write_ready", WriteReady, exp_wrdy);
    if (rd) exp_q.push_back(ref_mem[raddr]);
    if (wr && exp_wrdy) ref_mem[waddr] = wdata;
    @(posedge Clock);
    #1;
    Read  = 1'b0;
    Write = 1'b0;
    check_output(rd);
  endtask

  // Release reset and count cycles until Ready; requests during init are ignored.
  task automatic do_init();
    int n;
    n            = 0;
    Reset_N      = 1'b1;
    Read         = 1'b1;
    ReadAddress  = AW'(3);
    Write        = 1'b1;
    WriteAddress = AW'(1);
    DIn          = 16'hFFFF;
    while (n < 40) begin
      @(posedge Clock);
      #1;
      n++;
      check_val("init_read_valid", ReadValid, 1'b0);
      if (Ready) break;
    end
    Read  = 1'b0;
    Write = 1'b0;
    check_val("init_cycles", n, 8);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset_N      = 1'b0;
    Read         = 1'b0;
    ReadAddress  = '0;
    Write        = 1'b0;
    WriteAddress = '0;
    DIn          = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_ready", Ready, 1'b0);
    check_val("rst_write_ready", WriteReady, 1'b0);
    check_val("rst_read_valid", ReadValid, 1'b0);
    check_val("rst_dout", DOut, '0);

    do_init();

    // Every word reads back zero, back-to-back.
    for (int a = 0; a < 16; a++) cycle(1, a, 0, 0, '0, 1);

    // Different banks: write goes straight to bank 1 while bank 0 is read.
    cycle(1, 2, 1, 3, 16'h00AA, 1);
    cycle(1, 3, 0, 0, '0, 1);

    // Same-bank conflict: write buffered, forwarded, then drained.
    cycle(1, 4, 1, 6, 16'h0055, 1);
    cycle(1, 6, 0, 0, '0, 1);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(1, 6, 0, 0, '0, 1);

    // Backpressure: bank 0 kept busy by reads, third write refused.
    cycle(1, 0, 1, 10, 16'h0010, 1);
    cycle(1, 0, 1, 12, 16'h0012, 1);
    cycle(1, 0, 1, 14, 16'h0014, 0);
    cycle(0, 0, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(1, 10, 0, 0, '0, 1);
    cycle(1, 12, 0, 0, '0, 1);
    cycle(1, 14, 0, 0, '0, 1);

    // Duplicate addresses drain in order; youngest is forwarded.
    cycle(1, 0, 1, 8, 16'h0001, 1);
    cycle(1, 0, 1, 8, 16'h0002, 1);
    cycle(1, 8, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, '0, 0);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(1, 8, 0, 0, '0, 1);

    // Read-first on same-cycle read/write of one address.
    cycle(0, 0, 1, 5, 16'h0033, 1);
    cycle(1, 5, 1, 5, 16'h0077, 1);

    // Reset with one entry buffered and a read in flight.
    Read        = 1'b1;
    ReadAddress = AW'(5);
    Reset_N     = 1'b0;
    @(posedge Clock);
    #1;
    Read = 1'b0;
    check_val("mid_rst_ready", Ready, 1'b0);
    check_val("mid_rst_write_ready", WriteReady, 1'b0);
    check_val("mid_rst_read_valid", ReadValid, 1'b0);
    check_val("mid_rst_dout", DOut, '0);

    // Reset again partway through init; init restarts from address 0.
    Reset_N = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset_N = 1'b0;
    @(posedge Clock);
    #1;
    do_init();

    cycle(1, 5, 0, 0, '0, 1);
    cycle(1, 6, 0, 0, '0, 1);
    cycle(0, 0, 0, 0, '0, 1);

    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
